router_pkt_fifo: RTL and testbench
==================================

# router_pkt_fifo

Parametrised packet-aware FIFO, successor to the fixed 16x8 router output FIFO. It sits between the router register stage and each of the three output ports. Each word is stored with its header flag. The FIFO tracks packet boundaries on both sides, so it can report how many complete packets it holds and mark the parity byte on readout. No tristate output is used; validity is flagged explicitly.

## Interface
Parameters:
- DATA_W, 8: data width; header layout is {payload_len[DATA_W-1:2], addr[1:0]}
- DEPTH, 16: entries; power of two, ≥4
- AFULL_TH, DEPTH-2: almost_full asserts when count ≥ AFULL_TH

Ports:
- clk  in  1  clock
- rstn  in  1  asynchronous active-low reset
- soft_rst  in  1  synchronous flush, active-high
- wt_en  in  1  write request
- rd_en  in  1  read request
- lfd_state  in  1  current data_in is a header byte
- data_in  in  DATA_W  write data
- d_out  out  DATA_W  read data, registered
- d_valid  out  1  d_out holds a word popped last cycle
- d_hdr  out  1  d_out is a header byte
- d_eop  out  1  d_out is the parity (last) byte of a packet
- empty  out  1  count == 0
- full  out  1  count == DEPTH
- almost_full  out  1  count ≥ AFULL_TH
- count  out  $clog2(DEPTH)+1  words stored
- pkt_cnt  out  $clog2(DEPTH)+1  complete packets stored

## Operation
- Storage: DEPTH x (DATA_W+1); bit DATA_W = lfd_state at write. Pointers are $clog2(DEPTH) bits and wrap naturally.
- Write is accepted iff wt_en && !full. Read is accepted iff rd_en && !empty. full/empty are evaluated at the start of the cycle.
  - Write when full: dropped, no state change.
  - Read when empty: d_valid=0 next cycle; d_out holds its value.
- Simultaneous accepted read and write: count is unchanged, both pointers advance.
  - When full, only the read is accepted.
  - When empty, only the write is accepted; no fall-through.
- Write-side tracker wr_rem (DATA_W-1 bits):
  - Accepted write with lfd_state=1 loads wr_rem = payload_len+1. A header arriving mid-packet abandons the previous packet, which is never counted.
  - Accepted non-header write with wr_rem≠0 decrements wr_rem. The write that takes wr_rem 1→0 is the parity byte and completes a packet.
  - Non-header writes with wr_rem==0 are stored but not packet-tracked.
- Read-side tracker rd_rem works the same way on popped words, using the stored flag and the header's payload_len. The pop that takes rd_rem 1→0 is the parity byte: d_eop=1 and the packet retires.
- pkt_cnt:
  - +1 on packet completion at write, −1 on packet retire at read.
  - Both in one cycle: unchanged.
  - Never underflows; a retire with pkt_cnt==0 is ignored.
- payload_len=0 is a legal header: a 2-byte packet (header then parity).
- soft_rst: clears pointers, count, pkt_cnt, wr_rem, rd_rem, d_valid, d_hdr, d_eop and d_out to 0. soft_rst has priority over same-cycle reads and writes. Memory contents are not cleared.

## Timing
- Every output resets asynchronously to 0, except empty, which resets to 1.
- Read latency is 1. An accepted read at edge N presents the word on d_out/d_valid/d_hdr/d_eop after edge N. d_valid is a single-cycle pulse per pop.
- count, pkt_cnt, empty, full and almost_full are registered or derived from registered count. They update on the edge that accepts the operation.
- A word written at edge N is readable (empty=0) after edge N. A pop can occur at edge N+1.
- rstn deasserted mid-packet: all trackers restart; the next header begins a fresh packet.

## Structure
- Shared package router_pkg holds:
  - the PAYLOAD_LEN_LSB=2 and ADDR_W=2 constants
  - a function extracting payload_len from a header for a given DATA_W
  - a pointer-width function.
- Sub-module router_fifo_mem: a synchronous-write, registered-read dual-port array (DEPTH x DATA_W+1) with no reset on the array. Pointers, trackers and flags stay in router_pkt_fifo.

## Test plan
- Reset, then write header 8'h21 (len 8, addr 01), 8 payload bytes and parity → count=10, pkt_cnt=1. Read 10 → d_hdr on the 1st pop, d_eop on the 10th, then pkt_cnt=0 and empty=1.
- DEPTH=16: write 17 words → full=1 after the 16th, 17th dropped. almost_full=1 from count=14. Read 16 → data in order, pointer wrap is correct.
- Read on empty (rd_en held 3 cycles) → d_valid=0, count stays 0, no underflow.
- With count=5: wt_en and rd_en together for 4 cycles → count stays 5, data order preserved. Repeat with full=1 → only reads are accepted.
- Write header 8'h0D (len 3), then 2 payload bytes, then header 8'h02 (len 0) and a parity byte → pkt_cnt=1, not 2. The first packet is abandoned.
- Write 2 complete packets, pulse soft_rst mid-third-packet → count=0, pkt_cnt=0, empty=1, d_valid=0. The next packet is tracked correctly.
- Rerun scenarios 1 and 2 with DATA_W=16, DEPTH=64.

Source files
------------

// File: rtl/router_pkg.sv
// ---------------------------------------------------------------------------
// router_pkg
// Shared definitions for the router packet FIFO slice.
//
// Contents:
//   PAYLOAD_LEN_LSB : bit position where payload_len starts inside a header
//   ADDR_W          : width of the destination address field of a header
//   ptr_width()     : pointer width for a FIFO of a given depth
//   payload_len()   : extracts payload_len from a header word of width dataW
// ---------------------------------------------------------------------------
package router_pkg;

  localparam int ADDR_W          = 2;
  localparam int PAYLOAD_LEN_LSB = ADDR_W;

  // Pointer width for a power-of-two FIFO. A depth of 1 still needs one bit
  // so that the pointer declarations stay legal.
  function automatic int ptr_width(input int depth);
    return (depth <= 1) ? 1 : $clog2(depth);
  endfunction

  // A header is laid out as {payload_len, addr}. Bits above dataW are masked
  // off so callers can pass any zero-extended word.
  function automatic logic [31:0] payload_len(input logic [63:0] hdr,
                                              input int          dataW);
    logic [63:0] masked;
    masked = hdr & ((64'd1 << dataW) - 64'd1);
    return 32'(masked >> PAYLOAD_LEN_LSB);
  endfunction

endpackage

// File: rtl/router_fifo_mem.sv
// ---------------------------------------------------------------------------
// router_fifo_mem
// Dual-port storage array for router_pkt_fifo. Synchronous write, registered
// read. The read register always holds the word at i_raddr as seen after the
// current edge, so the owner drives i_raddr with the *next* read pointer and
// finds the head-of-queue word waiting in o_rdata one cycle later.
//
// Ports:
//   clk     in   clock
//   rstn    in   asynchronous active-low reset (read register only)
//   i_we    in   write enable
//   i_waddr in   write address
//   i_wdata in   write data
//   i_raddr in   read address for the next registered read
//   o_rdata out  registered read data
// ---------------------------------------------------------------------------
module router_fifo_mem #(
  parameter int WIDTH = 9,
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             i_we,
  input  logic [AW-1:0]    i_waddr,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic [AW-1:0]    i_raddr,
  output logic [WIDTH-1:0] o_rdata
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [WIDTH-1:0] r_rdata;

  // Storage array: written on accepted pushes only, never reset or cleared.
  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  // Registered read. When the word being written lands on the address being
  // read, the new data is forwarded so a push into an empty FIFO shows up at
  // the head immediately after the write edge.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_rdata <= '0;
    end else if (i_we && (i_waddr == i_raddr)) begin
      r_rdata <= i_wdata;
    end else begin
      r_rdata <= r_mem[i_raddr];
    end
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/router_pkt_fifo.sv
// ---------------------------------------------------------------------------
// router_pkt_fifo
// Packet-aware output FIFO between the router register stage and an output
// port. Each word is stored together with its header flag. Independent
// trackers on the write and read sides follow packet boundaries, so the FIFO
// can count complete packets held and flag the parity byte when it is popped.
//
// Parameters:
//   DATA_W   : data width, header = {payload_len[DATA_W-1:2], addr[1:0]}
//   DEPTH    : number of entries, power of two, >= 4
//   AFULL_TH : almost_full asserts when count >= AFULL_TH
//
// Ports:
//   clk          in   clock
//   rstn         in   asynchronous active-low reset
//   soft_rst     in   synchronous flush, wins over same-cycle read/write
//   wt_en        in   write request, accepted when not full
//   rd_en        in   read request, accepted when not empty
//   lfd_state    in   data_in is a header byte
//   data_in      in   write data
//   d_out        out  registered read data, holds between pops
//   d_valid      out  one-cycle pulse: d_out was popped on the last edge
//   d_hdr        out  d_out is a header byte
//   d_eop        out  d_out is the parity (last) byte of a packet
//   empty        out  count == 0
//   full         out  count == DEPTH
//   almost_full  out  count >= AFULL_TH
//   count        out  words stored
//   pkt_cnt      out  complete packets stored
// ---------------------------------------------------------------------------
module router_pkt_fifo
  import router_pkg::*;
#(
  parameter int DATA_W   = 8,
  parameter int DEPTH    = 16,
  parameter int AFULL_TH = DEPTH - 2
) (
  input  logic                       clk,
  input  logic                       rstn,
  input  logic                       soft_rst,
  input  logic                       wt_en,
  input  logic                       rd_en,
  input  logic                       lfd_state,
  input  logic [DATA_W-1:0]          data_in,
  output logic [DATA_W-1:0]          d_out,
  output logic                       d_valid,
  output logic                       d_hdr,
  output logic                       d_eop,
  output logic                       empty,
  output logic                       full,
  output logic                       almost_full,
  output logic [$clog2(DEPTH):0]     count,
  output logic [$clog2(DEPTH):0]     pkt_cnt
);

  localparam int AW = ptr_width(DEPTH);
  localparam int CW = $clog2(DEPTH) + 1;
  localparam int RW = DATA_W - 1;

  logic [AW-1:0]     r_wrPtr;
  logic [AW-1:0]     r_rdPtr;
  logic [AW-1:0]     w_rdPtrNext;
  logic [CW-1:0]     r_count;
  logic [CW-1:0]     r_pktCnt;
  logic [RW-1:0]     r_wrRem;
  logic [RW-1:0]     r_rdRem;
  logic [RW-1:0]     w_wrLen;
  logic [RW-1:0]     w_rdLen;
  logic [DATA_W:0]   w_head;
  logic              w_headHdr;
  logic [DATA_W-1:0] w_headData;
  logic              w_wrAcc;
  logic              w_rdAcc;
  logic              w_memWe;
  logic              w_wrDone;
  logic              w_rdDone;
  logic              w_retire;
  logic [DATA_W-1:0] r_dOut;
  logic              r_dValid;
  logic              r_dHdr;
  logic              r_dEop;

  // Status flags all come straight from the registered word count, so they
  // describe the FIFO as it stands at the start of the cycle.
  assign empty       = (r_count == '0);
  assign full        = (r_count == CW'(DEPTH));
  assign almost_full = (r_count >= CW'(AFULL_TH));

  assign w_wrAcc = wt_en && !full;
  assign w_rdAcc = rd_en && !empty;
  assign w_memWe = w_wrAcc && !soft_rst;

  assign w_headHdr  = w_head[DATA_W];
  assign w_headData = w_head[DATA_W-1:0];

  // Remaining-byte reload values: payload bytes plus the trailing parity.
  assign w_wrLen = RW'(payload_len(64'(data_in), DATA_W)) + RW'(1);
  assign w_rdLen = RW'(payload_len(64'(w_headData), DATA_W)) + RW'(1);

  // The non-header byte that brings a tracker from 1 to 0 is the parity
  // byte and closes the packet on that side.
  assign w_wrDone = w_wrAcc && !lfd_state && (r_wrRem == RW'(1));
  assign w_rdDone = w_rdAcc && !w_headHdr && (r_rdRem == RW'(1));
  assign w_retire = w_rdDone && (r_pktCnt != '0);

  // The memory read register is fed with the pointer it will hold after this
  // edge, which keeps the head-of-queue word ready for the next pop.
  always_comb begin
    w_rdPtrNext = r_rdPtr;
    if (soft_rst) begin
      w_rdPtrNext = '0;
    end else if (w_rdAcc) begin
      w_rdPtrNext = r_rdPtr + AW'(1);
    end
  end

  router_fifo_mem #(
    .WIDTH (DATA_W + 1),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_mem (
    .clk     (clk),
    .rstn    (rstn),
    .i_we    (w_memWe),
    .i_waddr (r_wrPtr),
    .i_wdata ({lfd_state, data_in}),
    .i_raddr (w_rdPtrNext),
    .o_rdata (w_head)
  );

  // Pointers and word count. A simultaneous accepted push and pop moves both
  // pointers and leaves the count alone.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_count <= '0;
    end else if (soft_rst) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_count <= '0;
    end else begin
      r_rdPtr <= w_rdPtrNext;
      if (w_wrAcc) begin
        r_wrPtr <= r_wrPtr + AW'(1);
      end
      case ({w_wrAcc, w_rdAcc})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Packet trackers. A header always reloads, which silently abandons any
  // packet still in progress on that side. Stray non-header bytes seen with
  // the tracker at zero are stored but not counted toward any packet.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_wrRem <= '0;
      r_rdRem <= '0;
    end else if (soft_rst) begin
      r_wrRem <= '0;
      r_rdRem <= '0;
    end else begin
      if (w_wrAcc) begin
        if (lfd_state) begin
          r_wrRem <= w_wrLen;
        end else if (r_wrRem != '0) begin
          r_wrRem <= r_wrRem - RW'(1);
        end
      end
      if (w_rdAcc) begin
        if (w_headHdr) begin
          r_rdRem <= w_rdLen;
        end else if (r_rdRem != '0) begin
          r_rdRem <= r_rdRem - RW'(1);
        end
      end
    end
  end

  // Complete-packet count. A retire with nothing counted is dropped so an
  // abandoned or flushed packet can never drive the count below zero.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_pktCnt <= '0;
    end else if (soft_rst) begin
      r_pktCnt <= '0;
    end else begin
      case ({w_wrDone, w_retire})
        2'b10:   r_pktCnt <= r_pktCnt + CW'(1);
        2'b01:   r_pktCnt <= r_pktCnt - CW'(1);
        default: r_pktCnt <= r_pktCnt;
      endcase
    end
  end

  // Read-side output register. The popped word and its header/parity flags
  // are captured together and held until the next pop; only d_valid pulses.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_dOut   <= '0;
      r_dValid <= 1'b0;
      r_dHdr   <= 1'b0;
      r_dEop   <= 1'b0;
    end else if (soft_rst) begin
      r_dOut   <= '0;
      r_dValid <= 1'b0;
      r_dHdr   <= 1'b0;
      r_dEop   <= 1'b0;
    end else if (w_rdAcc) begin
      r_dOut   <= w_headData;
      r_dValid <= 1'b1;
      r_dHdr   <= w_headHdr;
      r_dEop   <= w_rdDone;
    end else begin
      r_dValid <= 1'b0;
    end
  end

  assign d_out   = r_dOut;
  assign d_valid = r_dValid;
  assign d_hdr   = r_dHdr;
  assign d_eop   = r_dEop;
  assign count   = r_count;
  assign pkt_cnt = r_pktCnt;

endmodule

// File: tb/tb_router_pkt_fifo.sv
// ---------------------------------------------------------------------------
// tb_router_pkt_fifo
// Drives two instances of router_pkt_fifo (8-bit x16 and 16-bit x64) one at a
// time, selected by sel, and compares them with a queue-based packet model.
// ---------------------------------------------------------------------------
module tb_router_pkt_fifo;

  typedef struct {
    logic        hdr;
    logic [15:0] data;
  } word_t;

  logic        clk = 1'b0;
  logic        rstn = 1'b1;
  logic        softRst = 1'b0;
  logic        wtEn = 1'b0;
  logic        rdEn = 1'b0;
  logic        lfd = 1'b0;
  logic        sel = 1'b0;
  logic [15:0] dataIn = '0;

  logic [7:0]  dOut8;
  logic        dValid8, dHdr8, dEop8, empty8, full8, af8;
  logic [4:0]  count8, pkt8;
  logic [15:0] dOut16;
  logic        dValid16, dHdr16, dEop16, empty16, full16, af16;
  logic [6:0]  count16, pkt16;

  logic [15:0] obsDout;
  logic        obsValid, obsHdr, obsEop, obsEmpty, obsFull, obsAf;
  logic [6:0]  obsCount, obsPkt;

  // Model state
  word_t       q[$];
  int          curW = 8;
  int          curDepth = 16;
  int          wrRem = 0;
  int          rdRem = 0;
  int          mPkt = 0;
  logic        expValid = 1'b0;
  logic        expHdr = 1'b0;
  logic        expEop = 1'b0;
  logic [15:0] expDout = '0;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  router_pkt_fifo u_dut8 (
    .clk         (clk),
    .rstn        (rstn),
    .soft_rst    (softRst & ~sel),
    .wt_en       (wtEn & ~sel),
    .rd_en       (rdEn & ~sel),
    .lfd_state   (lfd),
    .data_in     (dataIn[7:0]),
    .d_out       (dOut8),
    .d_valid     (dValid8),
    .d_hdr       (dHdr8),
    .d_eop       (dEop8),
    .empty       (empty8),
    .full        (full8),
    .almost_full (af8),
    .count       (count8),
    .pkt_cnt     (pkt8)
  );

  router_pkt_fifo #(.DATA_W(16), .DEPTH(64)) u_dut16 (
    .clk         (clk),
    .rstn        (rstn),
    .soft_rst    (softRst & sel),
    .wt_en       (wtEn & sel),
    .rd_en       (rdEn & sel),
    .lfd_state   (lfd),
    .data_in     (dataIn),
    .d_out       (dOut16),
    .d_valid     (dValid16),
    .d_hdr       (dHdr16),
    .d_eop       (dEop16),
    .empty       (empty16),
    .full        (full16),
    .almost_full (af16),
    .count       (count16),
    .pkt_cnt     (pkt16)
  );

  // Present whichever instance is under test on one set of observation wires.
  always_comb begin
    if (sel) begin
      obsDout  = dOut16;
      obsValid = dValid16;
      obsHdr   = dHdr16;
      obsEop   = dEop16;
      obsEmpty = empty16;
      obsFull  = full16;
      obsAf    = af16;
      obsCount = count16;
      obsPkt   = pkt16;
    end else begin
      obsDout  = {8'h00, dOut8};
      obsValid = dValid8;
      obsHdr   = dHdr8;
      obsEop   = dEop8;
      obsEmpty = empty8;
      obsFull  = full8;
      obsAf    = af8;
      obsCount = {2'b00, count8};
      obsPkt   = {2'b00, pkt8};
    end
  end

  function automatic int lenOf(input logic [15:0] d);
    return int'(d >> 2);
  endfunction

  function automatic logic [15:0] mkHdr(input int len, input int addr);
    return 16'((len << 2) | (addr & 3));
  endfunction

  // Clears the model to its power-on / flushed state.
  task automatic modelClear();
    q.delete();
    wrRem    = 0;
    rdRem    = 0;
    mPkt     = 0;
    expValid = 1'b0;
    expDout  = '0;
    expHdr   = 1'b0;
    expEop   = 1'b0;
  endtask

  // Updates the model for one cycle of requests, drives the DUT, then waits
  // until just after the clock edge that consumes them.
  task automatic applyStimulus(input logic we, input logic re, input logic lf,
                               input logic sr, input logic [15:0] din);
    word_t       e;
    logic        wAcc, rAcc, done, retire;
    logic [15:0] dm;
    dm     = (curW == 8) ? {8'h00, din[7:0]} : din;
    done   = 1'b0;
    retire = 1'b0;
    if (sr) begin
      modelClear();
    end else begin
      wAcc = we && (q.size() < curDepth);
      rAcc = re && (q.size() > 0);
      if (rAcc) begin
        e        = q.pop_front();
        expValid = 1'b1;
        expDout  = e.data;
        expHdr   = e.hdr;
        expEop   = !e.hdr && (rdRem == 1);
        retire   = expEop;
        if (e.hdr) rdRem = lenOf(e.data) + 1;
        else if (rdRem > 0) rdRem--;
      end else begin
        expValid = 1'b0;
      end
      if (wAcc) begin
        done = !lf && (wrRem == 1);
        if (lf) wrRem = lenOf(dm) + 1;
        else if (wrRem > 0) wrRem--;
        e.hdr  = lf;
        e.data = dm;
        q.push_back(e);
      end
      mPkt = mPkt + (done ? 1 : 0) - ((retire && mPkt > 0) ? 1 : 0);
    end
    softRst = sr;
    wtEn    = we;
    rdEn    = re;
    lfd     = lf;
    dataIn  = din;
    @(posedge clk);
    #1;
    softRst = 1'b0;
    wtEn    = 1'b0;
    rdEn    = 1'b0;
    lfd     = 1'b0;
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    modelClear();
    #2;
    total++; if (obsCount !== 7'd0) begin bad++; $display("[TB] FAIL rst_count: got %0d want 0", obsCount); end
    total++; if (obsPkt !== 7'd0) begin bad++; $display("[TB] FAIL rst_pkt: got %0d want 0", obsPkt); end
    total++; if (obsEmpty !== 1'b1) begin bad++; $display("[TB] FAIL rst_empty: got %b want 1", obsEmpty); end
    total++; if (obsFull !== 1'b0) begin bad++; $display("[TB] FAIL rst_full: got %b want 0", obsFull); end
    total++; if (obsAf !== 1'b0) begin bad++; $display("[TB] FAIL rst_afull: got %b want 0", obsAf); end
    total++; if ({obsValid, obsHdr, obsEop} !== 3'b000) begin bad++; $display("[TB] FAIL rst_flags: got %b want 000", {obsValid, obsHdr, obsEop}); end
    total++; if (obsDout !== 16'h0000) begin bad++; $display("[TB] FAIL rst_dout: got %h want 0000", obsDout); end
    @(negedge clk);
    rstn = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_packet();
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 16'h0021);
    for (int i = 0; i < 9; i++) applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 16'($urandom));
    total++; if (obsCount !== 7'd10) begin bad++; $display("[TB] FAIL pkt_count: got %0d want 10", obsCount); end
    total++; if (obsPkt !== 7'd1) begin bad++; $display("[TB] FAIL pkt_cnt_wr: got %0d want 1", obsPkt); end
    for (int i = 0; i < 10; i++) begin
      applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 16'h0000);
      total++; if (obsValid !== 1'b1) begin bad++; $display("[TB] FAIL pkt_valid[%0d]: got %b want 1", i, obsValid); end
      total++; if (obsDout !== expDout) begin bad++; $display("[TB] FAIL pkt_dout[%0d]: got %h want %h", i, obsDout, expDout); end
      total++; if (obsHdr !== (i == 0)) begin bad++; $display("[TB] FAIL pkt_hdr[%0d]: got %b want %b", i, obsHdr, (i == 0)); end
      total++; if (obsEop !== (i == 9)) begin bad++; $display("[TB] FAIL pkt_eop[%0d]: got %b want %b", i, obsEop, (i == 9)); end
    end
    total++; if (obsPkt !== 7'd0) begin bad++; $display("[TB] FAIL pkt_cnt_rd: got %0d want 0", obsPkt); end
    total++; if (obsEmpty !== 1'b1) begin bad++; $display("[TB] FAIL pkt_empty: got %b want 1", obsEmpty); end
  endtask

  task automatic test_fill();
    for (int i = 0; i < curDepth + 1; i++) begin
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 16'($urandom));
      total++; if (obsCount !== 7'(q.size())) begin bad++; $display("[TB] FAIL fill_count[%0d]: got %0d want %0d", i, obsCount, q.size()); end
      total++; if (obsFull !== (q.size() == curDepth)) begin bad++; $display("[TB] FAIL fill_full[%0d]: got %b want %b", i, obsFull, (q.size() == curDepth)); end
      total++; if (obsAf !== (q.size() >= curDepth - 2)) begin bad++; $display("[TB] FAIL fill_afull[%0d]: got %b want %b", i, obsAf, (q.size() >= curDepth - 2)); end
    end
    for (int i = 0; i < curDepth; i++) begin
      applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 16'h0000);
      total++; if (obsValid !== 1'b1 || obsDout !== expDout) begin bad++; $display("[TB] FAIL drain_data[%0d]: got %b/%h want 1/%h", i, obsValid, obsDout, expDout); end
      total++; if (obsCount !== 7'(q.size())) begin bad++; $display("[TB] FAIL drain_count[%0d]: got %0d want %0d", i, obsCount, q.size()); end
    end
    total++; if (obsEmpty !== 1'b1) begin bad++; $display("[TB] FAIL drain_empty: got %b want 1", obsEmpty); end
  endtask

  task automatic test_read_empty();
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 16'h0000);
      total++; if (obsValid !== 1'b0) begin bad++; $display("[TB] FAIL rdempty_valid[%0d]: got %b want 0", i, obsValid); end
      total++; if (obsCount !== 7'd0) begin bad++; $display("[TB] FAIL rdempty_count[%0d]: got %0d want 0", i, obsCount); end
      total++; if (obsDout !== expDout) begin bad++; $display("[TB] FAIL rdempty_hold[%0d]: got %h want %h", i, obsDout, expDout); end
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 5; i++) applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 16'($urandom));
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 16'($urandom));
      total++; if (obsCount !== 7'd5) begin bad++; $display("[TB] FAIL b2b_count[%0d]: got %0d want 5", i, obsCount); end
      total++; if (obsValid !== 1'b1 || obsDout !== expDout) begin bad++; $display("[TB] FAIL b2b_data[%0d]: got %b/%h want 1/%h", i, obsValid, obsDout, expDout); end
    end
    while (q.size() < curDepth) applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 16'($urandom));
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 16'($urandom));
      total++; if (obsCount !== 7'(q.size())) begin bad++; $display("[TB] FAIL b2bfull_count[%0d]: got %0d want %0d", i, obsCount, q.size()); end
      total++; if (obsValid !== 1'b1 || obsDout !== expDout) begin bad++; $display("[TB] FAIL b2bfull_data[%0d]: got %b/%h want 1/%h", i, obsValid, obsDout, expDout); end
    end
    while (q.size() > 0) begin
      applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 16'h0000);
      total++; if (obsDout !== expDout) begin bad++; $display("[TB] FAIL b2b_drain: got %h want %h", obsDout, expDout); end
    end
  endtask

  task automatic test_abandon();
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 16'h000D);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 16'($urandom));
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 16'($urandom));
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 16'h0002);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 16'($urandom));
    total++; if (obsPkt !== 7'd1) begin bad++; $display("[TB] FAIL abandon_pkt: got %0d want 1", obsPkt); end
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 16'h0000);
      total++; if (obsEop !== (i == 4)) begin bad++; $display("[TB] FAIL abandon_eop[%0d]: got %b want %b", i, obsEop, (i == 4)); end
    end
    total++; if (obsPkt !== 7'd0) begin bad++; $display("[TB] FAIL abandon_pkt_rd: got %0d want 0", obsPkt); end
  endtask

  task automatic test_soft_rst();
    int len;
    for (int p = 0; p < 2; p++) begin
      len = int'($urandom_range(0, 3));
      applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, mkHdr(len, p));
      for (int i = 0; i <= len; i++) applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 16'($urandom));
    end
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, mkHdr(3, 2));
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 16'($urandom));
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 16'h0000);
    total++; if (obsPkt !== 7'd2) begin bad++; $display("[TB] FAIL srst_pre_pkt: got %0d want 2", obsPkt); end
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, 16'($urandom));
    total++; if (obsCount !== 7'd0) begin bad++; $display("[TB] FAIL srst_count: got %0d want 0", obsCount); end
    total++; if (obsPkt !== 7'd0) begin bad++; $display("[TB] FAIL srst_pkt: got %0d want 0", obsPkt); end
    total++; if (obsEmpty !== 1'b1) begin bad++; $display("[TB] FAIL srst_empty: got %b want 1", obsEmpty); end
    total++; if (obsValid !== 1'b0 || obsDout !== 16'h0000) begin bad++; $display("[TB] FAIL srst_out: got %b/%h want 0/0000", obsValid, obsDout); end
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, mkHdr(2, 1));
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 16'($urandom));
    total++; if (obsPkt !== 7'd1) begin bad++; $display("[TB] FAIL srst_next_pkt: got %0d want 1", obsPkt); end
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 16'h0000);
      total++; if (obsEop !== (i == 3) || obsDout !== expDout) begin bad++; $display("[TB] FAIL srst_next_rd[%0d]: got eop=%b %h want eop=%b %h", i, obsEop, obsDout, (i == 3), expDout); end
    end
  endtask

  task automatic test_random(input int cycles);
    logic we, re, lf;
    logic [15:0] d;
    for (int c = 0; c < cycles; c++) begin
      we = ($urandom_range(0, 99) < 55);
      re = ($urandom_range(0, 99) < 45);
      lf = ($urandom_range(0, 5) == 0);
      d  = lf ? mkHdr(int'($urandom_range(0, 4)), int'($urandom_range(0, 3))) : 16'($urandom);
      applyStimulus(we, re, lf, 1'b0, d);
      total++; if (obsCount !== 7'(q.size())) begin bad++; $display("[TB] FAIL rnd_count[%0d]: got %0d want %0d", c, obsCount, q.size()); end
      total++; if (obsPkt !== 7'(mPkt)) begin bad++; $display("[TB] FAIL rnd_pkt[%0d]: got %0d want %0d", c, obsPkt, mPkt); end
      total++; if ({obsEmpty, obsFull, obsAf} !== {q.size() == 0, q.size() == curDepth, q.size() >= curDepth - 2}) begin bad++; $display("[TB] FAIL rnd_flags[%0d]: got %b%b%b want %b%b%b", c, obsEmpty, obsFull, obsAf, q.size() == 0, q.size() == curDepth, q.size() >= curDepth - 2); end
      total++; if (obsValid !== expValid) begin bad++; $display("[TB] FAIL rnd_valid[%0d]: got %b want %b", c, obsValid, expValid); end
      if (expValid) begin
        total++; if ({obsDout, obsHdr, obsEop} !== {expDout, expHdr, expEop}) begin bad++; $display("[TB] FAIL rnd_word[%0d]: got %h h%b e%b want %h h%b e%b", c, obsDout, obsHdr, obsEop, expDout, expHdr, expEop); end
      end
    end
  endtask

  initial begin
    sel      = 1'b0;
    curW     = 8;
    curDepth = 16;
    test_reset();
    test_packet();
    test_fill();
    test_read_empty();
    test_back_to_back();
    test_abandon();
    test_soft_rst();
    test_random(400);

    sel      = 1'b1;
    curW     = 16;
    curDepth = 64;
    test_reset();
    test_packet();
    test_fill();
    test_random(400);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
